// File: rtl/rc_arm_failsafe.sv
// rc_arm_failsafe: arming gesture + link-loss supervisor gating RC sticks; RC_FAILSAFE_RAMP_EN enables the failsafe throttle ramp
module rc_arm_failsafe #(
  parameter int REC_VAL_BIT_WIDTH = 8,
  parameter int CENTER_VAL = 128,
  parameter int STICK_LOW_MAX = 10,
  parameter int STICK_HIGH_MIN = 245,
  parameter int TIMEOUT_US = 50000,
  parameter int ARM_HOLD_US = 1000000,
  parameter int RAMP_STEP_US = 10000
) (
  input  logic                         us_clk,
  input  logic                         reset,
  input  logic                         throttle_pwm,
  input  logic                         yaw_pwm,
  input  logic                         roll_pwm,
  input  logic                         pitch_pwm,
  input  logic [REC_VAL_BIT_WIDTH-1:0] throttle_val,
  input  logic [REC_VAL_BIT_WIDTH-1:0] yaw_val,
  input  logic [REC_VAL_BIT_WIDTH-1:0] roll_val,
  input  logic [REC_VAL_BIT_WIDTH-1:0] pitch_val,
  output logic [REC_VAL_BIT_WIDTH-1:0] throttle_out,
  output logic [REC_VAL_BIT_WIDTH-1:0] yaw_out,
  output logic [REC_VAL_BIT_WIDTH-1:0] roll_out,
  output logic [REC_VAL_BIT_WIDTH-1:0] pitch_out,
  output logic                         armed,
  output logic                         link_ok,
  output logic                         failsafe
);
  localparam int W = REC_VAL_BIT_WIDTH;
  localparam int TW = $clog2(TIMEOUT_US + 1);
  localparam int HW = $clog2(ARM_HOLD_US);
  localparam logic [W-1:0] CENTER = W'(CENTER_VAL);
  localparam logic [W-1:0] LOW = W'(STICK_LOW_MAX);
  localparam logic [W-1:0] HIGH = W'(STICK_HIGH_MIN);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_US);
  localparam logic [HW-1:0] HOLD_LAST = HW'(ARM_HOLD_US - 1);
  typedef enum logic [2:0] {DISARMED, ARMING, ARMED, DISARMING, FAILSAFE} state_t;
  state_t state, next;
  logic [3:0] pwm, s1, s2, e, alive;
  logic [TW-1:0] cnt [4];
  logic [HW-1:0] hold;
  logic [W-1:0] thr_q, yaw_q, roll_q, pitch_q, fs_thr;
  logic arm_cond, disarm_cond, fly, ramp_done;
  assign pwm = {pitch_pwm, roll_pwm, yaw_pwm, throttle_pwm};
  always_ff @(posedge us_clk or posedge reset)
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      e <= '0;
      link_ok <= 1'b0;
      for (int i = 0; i < 4; i++) cnt[i] <= T_MAX;
    end else begin
      s1 <= pwm;
      s2 <= s1;
      e <= s2;
      link_ok <= &alive;
      for (int i = 0; i < 4; i++)
        cnt[i] <= (s2[i] & ~e[i]) ? '0 : (cnt[i] == T_MAX) ? cnt[i] : cnt[i] + 1'b1;
    end
  always_comb begin
    alive = '0;
    for (int i = 0; i < 4; i++) alive[i] = cnt[i] < T_MAX;
  end
  assign arm_cond = throttle_val <= LOW && yaw_val >= HIGH;
  assign disarm_cond = throttle_val <= LOW && yaw_val <= LOW;
  assign fly = state == ARMED || state == DISARMING;
  assign armed = fly;
  assign failsafe = state == FAILSAFE;
  always_comb begin
    next = state;
    case (state)
      DISARMED:  if (link_ok && arm_cond) next = ARMING;
      ARMING:    if (!link_ok || !arm_cond) next = DISARMED;
                 else if (hold == HOLD_LAST) next = ARMED;
      ARMED:     if (!link_ok) next = FAILSAFE;
                 else if (disarm_cond) next = DISARMING;
      DISARMING: if (!link_ok) next = FAILSAFE;
                 else if (!disarm_cond) next = ARMED;
                 else if (hold == HOLD_LAST) next = DISARMED;
      FAILSAFE:  if (ramp_done) next = DISARMED;
      default:   next = DISARMED;
    endcase
  end
  always_ff @(posedge us_clk or posedge reset)
    if (reset) begin
      state <= DISARMED;
      hold <= '0;
      thr_q <= '0;
      yaw_q <= CENTER;
      roll_q <= CENTER;
      pitch_q <= CENTER;
    end else begin
      state <= next;
      hold <= (next == state && (state == ARMING || state == DISARMING)) ? hold + 1'b1 : '0;
      thr_q <= throttle_val;
      yaw_q <= yaw_val;
      roll_q <= roll_val;
      pitch_q <= pitch_val;
    end
`ifdef RC_FAILSAFE_RAMP_EN
  localparam int RW = $clog2(RAMP_STEP_US + 1);
  localparam logic [RW-1:0] STEP_LAST = RW'(RAMP_STEP_US - 1);
  logic [W-1:0] ramp;
  logic [RW-1:0] rtmr;
  always_ff @(posedge us_clk or posedge reset)
    if (reset) begin
      ramp <= '0;
      rtmr <= '0;
    end else if (fly && next == FAILSAFE) begin
      ramp <= thr_q;
      rtmr <= '0;
    end else if (failsafe && ramp != '0) begin
      rtmr <= (rtmr == STEP_LAST) ? '0 : rtmr + 1'b1;
      ramp <= (rtmr == STEP_LAST) ? ramp - 1'b1 : ramp;
    end
  assign ramp_done = ramp == '0;
  assign fs_thr = ramp;
`else
  assign ramp_done = 1'b1;
  assign fs_thr = '0;
`endif
  assign throttle_out = fly ? thr_q : failsafe ? fs_thr : '0;
  assign yaw_out = fly ? yaw_q : CENTER;
  assign roll_out = fly ? roll_q : CENTER;
  assign pitch_out = fly ? pitch_q : CENTER;
endmodule
